alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU for the processor datapath. Executes FWD/ADD/SUB/AND/OR
//  in one step, MUL (shift-add) and logical/arithmetic shifts iteratively.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mul_seq.sv | 61 ++++++
 rtl/alu_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode and FSM state encodings shared by the sequential ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module : alu_mul_seq
// Brief  : Shift-add multiplier, one partial product per cycle; the start
//          cycle already adds the first one. Present only with ALU_MUL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef ALU_MUL_EN
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int C_CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [C_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] w_pp;

    assign w_pp    = r_mplier[0] ? r_mcand : '0;
    // product is the accumulator value after the current step; the last step
    // is flagged by done so the caller captures it on that same edge
    assign product = r_acc + w_pp;
    assign done    = step && (r_cnt == C_CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            r_mplier <= b >> 1;
            r_cnt    <= C_CW'(WIDTH-1);
        end else if (step) begin
            r_acc    <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - C_CW'(1);
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module : alu_seq
// Brief  : Multi-cycle ALU with valid/ready handshake; single-step logic ops,
//          iterative shifts and (with ALU_MUL_EN defined) shift-add multiply.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry
);

    localparam int C_SHW = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [C_SHW-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;

    logic             w_accept;
    logic [C_SHW-1:0] w_amt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH:0]   w_sh_in;
    logic [WIDTH:0]   w_sh_ex;
    logic             w_load;
    logic [WIDTH-1:0] w_res_d;
    logic             w_cy_d;

    // one-bit shift; the MSB of the return value is the bit shifted out
    function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v, input logic arith);
        if (arith)
            return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
        return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
    endfunction

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_amt    = data2[C_SHW-1:0];
    assign w_sum    = {1'b0, data1} + {1'b0, data2};
    assign w_dif    = {1'b0, data1} + {1'b0, ~data2} + (WIDTH+1)'(1);
    assign w_sh_in  = shift1(data1, select == OP_SRA);
    assign w_sh_ex  = shift1(r_work, r_op == OP_SRA);

`ifdef ALU_MUL_EN
    logic                 w_mul_start;
    logic                 w_mul_step;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_mul_prod;

    assign w_mul_start = w_accept && (select == OP_MUL);
    assign w_mul_step  = (r_state == ST_EXEC) && (r_op == OP_MUL);

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_mul_start),
        .step    (w_mul_step),
        .a       (data1),
        .b       (data2),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (select == OP_MUL) begin
`ifdef ALU_MUL_EN
                        w_next_state = ST_EXEC;
`else
                        w_next_state = ST_DONE;
`endif
                    end else if (is_shift(select) && (w_amt > C_SHW'(1))) begin
                        w_next_state = ST_EXEC;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
`ifdef ALU_MUL_EN
                if (r_op == OP_MUL) begin
                    if (w_mul_done)
                        w_next_state = ST_DONE;
                end else
`endif
                if (r_cnt == C_SHW'(1))
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // result/carry update: loaded only on the edge that finishes an operation
    always_comb begin
        w_load  = 1'b0;
        w_res_d = r_result;
        w_cy_d  = r_carry;
        if (w_accept) begin
            case (select)
                OP_FWD: begin w_load = 1'b1; w_res_d = data2;         w_cy_d = 1'b0; end
                OP_ADD: begin w_load = 1'b1; {w_cy_d, w_res_d} = w_sum; end
                OP_AND: begin w_load = 1'b1; w_res_d = data1 & data2; w_cy_d = 1'b0; end
                OP_OR:  begin w_load = 1'b1; w_res_d = data1 | data2; w_cy_d = 1'b0; end
                OP_SUB: begin w_load = 1'b1; {w_cy_d, w_res_d} = w_dif; end
                OP_MUL: begin
`ifndef ALU_MUL_EN
                    w_load  = 1'b1;
                    w_res_d = '0;
                    w_cy_d  = 1'b1;
`endif
                end
                OP_SLL, OP_SRA: begin
                    if (w_amt == '0) begin
                        w_load  = 1'b1;
                        w_res_d = data1;
                        w_cy_d  = 1'b0;
                    end else if (w_amt == C_SHW'(1)) begin
                        w_load  = 1'b1;
                        {w_cy_d, w_res_d} = w_sh_in;
                    end
                end
                default: ;
            endcase
        end else if (r_state == ST_EXEC) begin
`ifdef ALU_MUL_EN
            if (r_op == OP_MUL) begin
                if (w_mul_done) begin
                    w_load  = 1'b1;
                    w_res_d = w_mul_prod[WIDTH-1:0];
                    w_cy_d  = |w_mul_prod[2*WIDTH-1:WIDTH];
                end
            end else
`endif
            if (r_cnt == C_SHW'(1)) begin
                w_load = 1'b1;
                {w_cy_d, w_res_d} = w_sh_ex;
            end
        end
    end

    // shift working register and remaining-step counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op   <= OP_FWD;
            r_work <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_op   <= select;
            r_work <= w_sh_in[WIDTH-1:0];
            r_cnt  <= w_amt - C_SHW'(1);
        end else if ((r_state == ST_EXEC) && is_shift(r_op)) begin
            r_work <= w_sh_ex[WIDTH-1:0];
            r_cnt  <= r_cnt - C_SHW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_carry  <= 1'b0;
        end else if (w_load) begin
            r_result <= w_res_d;
            r_zero   <= (w_res_d == '0);
            r_neg    <= w_res_d[WIDTH-1];
            r_carry  <= w_cy_d;
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign neg    = r_neg;
    assign carry  = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module : tb_alu_seq
// Brief  : Directed self-checking bench for alu_seq (WIDTH=8); MUL checks
//          follow the ALU_MUL_EN build option.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [2:0] znc;
        logic [7:0] lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] select;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       neg;
    logic       carry;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1     (data1),
        .data2     (data2),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    // present one operation, then count edges until out_valid (bounded)
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        select = op; data1 = a; data2 = b; in_valid = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0; data1 = 8'h00; data2 = 8'h00;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({result, zero, neg, carry, out_valid, in_ready} !== {8'h00, 5'b00001}) begin
            errors++;
            $display("FAIL reset_state got res=%h z=%b n=%b c=%b ov=%b ir=%b want 00 0 0 0 0 1",
                     result, zero, neg, carry, out_valid, in_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ir=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_step();
        vec_t tbl [6];
        logic [10:0] got;
        tbl = '{'{OP_ADD, 8'hF0, 8'h20, 8'h10, 3'b001, 8'd1},
                '{OP_SUB, 8'h05, 8'h05, 8'h00, 3'b101, 8'd1},
                '{OP_SUB, 8'h03, 8'h05, 8'hFE, 3'b010, 8'd1},
                '{OP_AND, 8'hF0, 8'h3C, 8'h30, 3'b000, 8'd1},
                '{OP_OR,  8'h0F, 8'h30, 8'h3F, 3'b000, 8'd1},
                '{OP_FWD, 8'h11, 8'hA5, 8'hA5, 3'b010, 8'd1}};
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            got = {result, zero, neg, carry};
            checks++;
            if (edges != int'(tbl[i].lat)) begin
                errors++;
                $display("FAIL single_lat[%0d] got %0d edges want %0d", i, edges, tbl[i].lat);
            end
            checks++;
            if (got !== {tbl[i].res, tbl[i].znc}) begin
                errors++;
                $display("FAIL single_res[%0d] got res=%h znc=%b want res=%h znc=%b",
                         i, got[10:3], got[2:0], tbl[i].res, tbl[i].znc);
            end
            release_result();
        end
    endtask

    task automatic test_shift();
        vec_t tbl [7];
        logic [10:0] got;
        tbl = '{'{OP_SRA, 8'h90, 8'h03, 8'hF2, 3'b010, 8'd3},
                '{OP_SLL, 8'h81, 8'h01, 8'h02, 3'b001, 8'd1},
                '{OP_SLL, 8'h5A, 8'h00, 8'h5A, 3'b000, 8'd1},
                '{OP_SRA, 8'hA5, 8'h00, 8'hA5, 3'b010, 8'd1},
                '{OP_SLL, 8'h81, 8'h02, 8'h04, 3'b000, 8'd2},
                '{OP_SRA, 8'h7F, 8'h07, 8'h00, 3'b101, 8'd7},
                '{OP_SLL, 8'h81, 8'hF9, 8'h02, 3'b001, 8'd1}};
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            got = {result, zero, neg, carry};
            checks++;
            if (edges != int'(tbl[i].lat)) begin
                errors++;
                $display("FAIL shift_lat[%0d] got %0d edges want %0d", i, edges, tbl[i].lat);
            end
            checks++;
            if (got !== {tbl[i].res, tbl[i].znc}) begin
                errors++;
                $display("FAIL shift_res[%0d] got res=%h znc=%b want res=%h znc=%b",
                         i, got[10:3], got[2:0], tbl[i].res, tbl[i].znc);
            end
            release_result();
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        vec_t tbl [3];
        logic [10:0] got;
        tbl = '{'{OP_MUL, 8'h0C, 8'h0B, 8'h84, 3'b010, 8'd8},
                '{OP_MUL, 8'h10, 8'h10, 8'h00, 3'b101, 8'd8},
                '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 3'b001, 8'd8}};
        for (int i = 0; i < 3; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            got = {result, zero, neg, carry};
            checks++;
            if (edges != int'(tbl[i].lat)) begin
                errors++;
                $display("FAIL mul_lat[%0d] got %0d edges want %0d", i, edges, tbl[i].lat);
            end
            checks++;
            if (got !== {tbl[i].res, tbl[i].znc}) begin
                errors++;
                $display("FAIL mul_res[%0d] got res=%h znc=%b want res=%h znc=%b",
                         i, got[10:3], got[2:0], tbl[i].res, tbl[i].znc);
            end
            release_result();
        end
    endtask
`else
    task automatic test_mul_disabled();
        issue(OP_MUL, 8'h03, 8'h03);
        checks++;
        if (edges != 1) begin
            errors++;
            $display("FAIL mul_off_lat got %0d edges want 1", edges);
        end
        checks++;
        if ({result, zero, neg, carry} !== {8'h00, 3'b101}) begin
            errors++;
            $display("FAIL mul_off_res got res=%h z=%b n=%b c=%b want 00 1 0 1",
                     result, zero, neg, carry);
        end
        release_result();
    endtask
`endif

    task automatic test_hold();
        issue(OP_ADD, 8'h7F, 8'h01);
        checks++;
        if ({result, zero, neg, carry} !== {8'h80, 3'b010} || edges != 1) begin
            errors++;
            $display("FAIL hold_first got res=%h znc=%b%b%b edges=%0d want 80 010 1",
                     result, zero, neg, carry, edges);
        end
        for (int i = 0; i < 5; i++) begin
            select = OP_FWD; data2 = 8'h33; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({result, zero, neg, carry, out_valid, in_ready} !== {8'h80, 3'b010, 2'b10}) begin
                errors++;
                $display("FAIL hold_cycle[%0d] got res=%h znc=%b%b%b ov=%b ir=%b want 80 010 1 0",
                         i, result, zero, neg, carry, out_valid, in_ready);
            end
        end
        in_valid = 1'b0; data2 = 8'h00;
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h80) begin
            errors++;
            $display("FAIL hold_release got ov=%b ir=%b res=%h want 0 1 80", out_valid, in_ready, result);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_ignored got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midrun();
        bit seen = 1'b0;
        @(negedge clk);
        select = OP_SRA; data1 = 8'h7F; data2 = 8'h07; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({result, zero, neg, carry, out_valid, in_ready} !== {8'h00, 5'b00001}) begin
            errors++;
            $display("FAIL midrun_reset got res=%h z=%b n=%b c=%b ov=%b ir=%b want 00 0 0 0 0 1",
                     result, zero, neg, carry, out_valid, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen || in_ready !== 1'b1 || result !== 8'h00) begin
            errors++;
            $display("FAIL midrun_abort got seen_ov=%b ir=%b res=%h want 0 1 00", seen, in_ready, result);
        end
        issue(OP_ADD, 8'h02, 8'h03);
        checks++;
        if ({result, zero, neg, carry} !== {8'h05, 3'b000} || edges != 1) begin
            errors++;
            $display("FAIL midrun_recover got res=%h znc=%b%b%b edges=%0d want 05 000 1",
                     result, zero, neg, carry, edges);
        end
        release_result();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data1     = 8'h00;
        data2     = 8'h00;
        select    = OP_FWD;
        test_reset();
        test_single_step();
        test_shift();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        test_hold();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
